// File: rtl/mmio_store_buffer.sv
// Posted-write FIFO for core stores to the MMIO region (address MSB set).
// Drains in order to the peripheral bus over valid/ready with first-word fall-through.
module mmio_store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_we,
  input  logic [AW-1:0]           mem_addr,
  input  logic [DW-1:0]           mem_wdata,
  output logic                    bus_valid,
  input  logic                    bus_ready,
  output logic [AW-1:0]           bus_addr,
  output logic [DW-1:0]           bus_wdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          enq_req, enq, deq;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign bus_valid = !empty;
  assign bus_addr  = addr_q[rd_ptr_q];
  assign bus_wdata = data_q[rd_ptr_q];

  always_comb begin
    addr_d   = addr_q;
    data_d   = data_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    enq_req = mem_we & mem_addr[AW-1];
    deq     = bus_valid & bus_ready;
    // When full, the slot under wr_ptr is the head being popped this cycle, so overwriting it is safe.
    enq     = enq_req & (!full | deq);

    if (enq) begin
      addr_d[wr_ptr_q] = mem_addr;
      data_d[wr_ptr_q] = mem_wdata;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (deq) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if (enq_req && !enq) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mmio_store_buffer.sv
// Scoreboard bench for mmio_store_buffer: directed scenarios followed by random traffic.
module tb_mmio_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   mem_we;
  logic [AW-1:0]          mem_addr;
  logic [DW-1:0]          mem_wdata;
  logic                   bus_valid;
  logic                   bus_ready;
  logic [AW-1:0]          bus_addr;
  logic [DW-1:0]          bus_wdata;
  logic                   full;
  logic                   empty;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;
  logic                   ovf_clr;

  mmio_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .bus_valid(bus_valid), .bus_ready(bus_ready),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: the FIFO contents as a queue of {addr,data}, plus the sticky flag.
  logic [AW+DW-1:0] exp_q[$];
  int               m_cnt = 0;
  logic             m_ovf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted bus beat must match the oldest outstanding store.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && bus_valid && bus_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL beat_unexpected: got addr 0x%0h data 0x%0h expected no beat", bus_addr, bus_wdata);
        end else begin
          logic [AW+DW-1:0] e;
          e = exp_q.pop_front();
          chk("beat_addr", 64'(bus_addr), 64'(e[AW+DW-1:DW]));
          chk("beat_data", 64'(bus_wdata), 64'(e[DW-1:0]));
        end
      end
    end
  end

  // Drive one cycle, advance the model by the same edge, then check the status outputs.
  task automatic step(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic rdy, input logic clr, input logic rst);
    logic req, acc, dq;
    mem_we = we; mem_addr = a; mem_wdata = d; bus_ready = rdy; ovf_clr = clr; reset = rst;
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      dq  = (m_cnt > 0) && rdy;
      req = we && a[AW-1];
      acc = req && ((m_cnt < int'(DEPTH)) || dq);
      if (acc) exp_q.push_back({a, d});
      m_cnt = m_cnt + (acc ? 1 : 0) - (dq ? 1 : 0);
      if (req && !acc) m_ovf = 1'b1;
      else if (clr)    m_ovf = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("count",     64'(count),     64'(m_cnt));
    chk("empty",     64'(empty),     64'(m_cnt == 0));
    chk("full",      64'(full),      64'(m_cnt == int'(DEPTH)));
    chk("bus_valid", 64'(bus_valid), 64'(m_cnt > 0));
    chk("overflow",  64'(overflow),  64'(m_ovf));
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, '0, '0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    mem_we = 0; mem_addr = '0; mem_wdata = '0; bus_ready = 0; ovf_clr = 0; reset = 1;
    @(posedge clk); #1;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    chk("rst_bus_addr",  64'(bus_addr),  64'h0);
    chk("rst_bus_wdata", 64'(bus_wdata), 64'h0);

    // Single MMIO store drains in one beat.
    step(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);
    chk("fwft_addr", 64'(bus_addr),  64'h8000_0010);
    chk("fwft_data", 64'(bus_wdata), 64'hDEAD_BEEF);
    idle(1'b1);

    // RAM store is ignored.
    step(1'b1, 32'h0000_0040, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    idle(1'b1);

    // Fill with ready low, overflow on the fifth store, then clear it.
    for (int i = 1; i <= 4; i++) step(1'b1, 32'h8000_0100 + 32'(i), 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h8000_0200, 32'h5, 1'b0, 1'b0, 1'b0);
    // Set wins over clear in the same cycle.
    step(1'b1, 32'h8000_0204, 32'h6, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);

    // Full with simultaneous pop and push: accepted, count holds.
    step(1'b1, 32'h8000_0300, 32'h77, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Reset with three entries pending, then fresh stores must not show stale data.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h8000_0400 + 32'(i), 32'hA0 + 32'(i), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h8000_0500, 32'hBEE5, 1'b0, 1'b0, 1'b0);
    chk("post_rst_addr", 64'(bus_addr),  64'h8000_0500);
    chk("post_rst_data", 64'(bus_wdata), 64'hBEE5);
    idle(1'b1);

    // Random traffic with occasional clears and resets.
    for (int i = 0; i < 400; i++) begin
      logic [AW-1:0] a;
      a = $urandom;
      step(1'($urandom_range(0, 99) < 70), a, $urandom,
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 9) == 0),
           1'($urandom_range(0, 199) == 0));
    end

    for (int i = 0; i < int'(DEPTH) + 2; i++) idle(1'b1);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
